// File: rtl/clk_pkg.sv
// Shared definitions for the clock-switch controller: source count, error codes, FSM states.
package clk_pkg;

   localparam int NUM_SRC = 4;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_NOT_ALIVE = 2'd1;
   localparam logic [1:0] ERR_LOST      = 2'd2;
   localparam logic [1:0] ERR_FALLBACK  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_MUXRST = 2'd2
   } state_t;

endpackage

// File: rtl/clk_activity_mon.sv
// Activity monitor for one candidate clock: toggle flop, 2-flop sync into clk0,
// edge detect and a retriggerable alive window.
module clk_activity_mon #(
   parameter int ALIVE_WIN = 16
) (
   input  logic clk0,
   input  logic rst_n,
   input  logic clk_src,
   output logic alive
);

   localparam int CW = $clog2(ALIVE_WIN + 1);

   logic          tog;
   logic [2:0]    sync_q;
   logic          toggle_seen;
   logic [CW-1:0] win_cnt;

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) tog <= 1'b0;
      else        tog <= ~tog;
   end

   // sync_q[1:0] is the synchronizer, sync_q[2] holds the previous value for edge detection
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], tog};
   end

   assign toggle_seen = sync_q[2] ^ sync_q[1];

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n)              win_cnt <= '0;
      else if (toggle_seen)    win_cnt <= CW'(ALIVE_WIN);
      else if (win_cnt != '0)  win_cnt <= win_cnt - CW'(1);
   end

   assign alive = (win_cnt != '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Control side of the glitch-free 4:1 clock mux: request handling, settle timing,
// abort and automatic fallback to the always-on source 0.
module clk_switch_ctrl
   import clk_pkg::*;
#(
   parameter int SETTLE_CYC = 8,
   parameter int ALIVE_WIN  = 16,
   parameter int MUXRST_CYC = 2
) (
   input  logic               clk0,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] clk_in,
   input  logic               req_valid,
   input  logic [1:0]         req_sel,
   output logic               req_ready,
   input  logic               auto_fallback_en,
   output logic [1:0]         sel,
   output logic               mux_rst_n,
   output logic [1:0]         cur_sel,
   output logic [NUM_SRC-1:0] alive,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);

   localparam int CNT_MAX = (SETTLE_CYC > MUXRST_CYC) ? SETTLE_CYC : MUXRST_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d, cur_sel_q, cur_sel_d, tgt_q, tgt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mux_rst_q, mux_rst_d;
   logic             pend_q, pend_d;
   logic [1:0]       pend_code_q, pend_code_d;
   logic             done_q, done_d, err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             fb_take;
   logic             unused_clk_in0;

   // Source 0 is the reference clock itself and is alive by definition
   assign alive[0]       = 1'b1;
   assign unused_clk_in0 = clk_in[0];

   for (genvar i = 1; i < NUM_SRC; i++) begin : g_mon
      clk_activity_mon #(.ALIVE_WIN(ALIVE_WIN)) u_mon (
         .clk0    (clk0),
         .rst_n   (rst_n),
         .clk_src (clk_in[i]),
         .alive   (alive[i])
      );
   end

   assign fb_take = auto_fallback_en && (cur_sel_q != 2'd0) && !alive[cur_sel_q];

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= 2'd0;
         cur_sel_q   <= 2'd0;
         tgt_q       <= 2'd0;
         cnt_q       <= '0;
         mux_rst_q   <= 1'b1;
         pend_q      <= 1'b0;
         pend_code_q <= ERR_NONE;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cur_sel_q   <= cur_sel_d;
         tgt_q       <= tgt_d;
         cnt_q       <= cnt_d;
         mux_rst_q   <= mux_rst_d;
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cur_sel_d   = cur_sel_q;
      tgt_d       = tgt_q;
      cnt_d       = cnt_q;
      mux_rst_d   = mux_rst_q;
      pend_d      = pend_q;
      pend_code_d = pend_code_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      req_ready   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Fallback wins over a simultaneous request by withdrawing ready
            req_ready = !fb_take;
            if (fb_take) begin
               sel_d       = 2'd0;
               tgt_d       = 2'd0;
               mux_rst_d   = 1'b0;
               cnt_d       = CNT_W'(MUXRST_CYC - 1);
               pend_code_d = ERR_FALLBACK;
               state_d     = ST_MUXRST;
            end else if (req_valid) begin
               if (req_sel == cur_sel_q) begin
                  done_d = 1'b1;
               end else if (!alive[req_sel]) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_NOT_ALIVE;
               end else begin
                  sel_d   = req_sel;
                  tgt_d   = req_sel;
                  pend_d  = 1'b0;
                  cnt_d   = CNT_W'(SETTLE_CYC - 1);
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (!alive[tgt_q]) begin
               sel_d       = 2'd0;
               tgt_d       = 2'd0;
               mux_rst_d   = 1'b0;
               cnt_d       = CNT_W'(MUXRST_CYC - 1);
               pend_code_d = ERR_LOST;
               state_d     = ST_MUXRST;
            end else if (cnt_q == '0) begin
               cur_sel_d = tgt_q;
               state_d   = ST_IDLE;
               if (pend_q) begin
                  err_d      = 1'b1;
                  err_code_d = pend_code_q;
                  pend_d     = 1'b0;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_MUXRST: begin
            if (cnt_q == '0) begin
               mux_rst_d = 1'b1;
               pend_d    = 1'b1;
               cnt_d     = CNT_W'(SETTLE_CYC - 1);
               state_d   = ST_SETTLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sel       = sel_q;
   assign cur_sel   = cur_sel_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign mux_rst_n = rst_n & mux_rst_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl: switch, reject, same-source,
// fallback (enabled and disabled), abort in settle, and reset mid-settle.
module tb_clk_switch_ctrl;

   logic       clk0 = 1'b0;
   logic       clk1 = 1'b0, clk2 = 1'b0, clk3 = 1'b0;
   logic       run1 = 1'b0, run2 = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] clk_in;
   logic       req_valid = 1'b0;
   logic [1:0] req_sel = 2'd0;
   logic       auto_fallback_en = 1'b0;
   logic       req_ready, mux_rst_n, done, err;
   logic [1:0] sel, cur_sel, err_code;
   logic [3:0] alive;

   int n_cmp = 0;
   int n_bad = 0;

   assign clk_in = {clk3, clk2, clk1, clk0};

   clk_switch_ctrl dut (
      .clk0             (clk0),
      .rst_n            (rst_n),
      .clk_in           (clk_in),
      .req_valid        (req_valid),
      .req_sel          (req_sel),
      .req_ready        (req_ready),
      .auto_fallback_en (auto_fallback_en),
      .sel              (sel),
      .mux_rst_n        (mux_rst_n),
      .cur_sel          (cur_sel),
      .alive            (alive),
      .done             (done),
      .err              (err),
      .err_code         (err_code)
   );

   always #5 clk0 = ~clk0;

   // clk1 runs at clk0/2, locked to clk0 negedges so the stop point is deterministic
   always @(negedge clk0) if (run1) clk1 = ~clk1;

   // clk2 runs at clk0/3, offset from clk0 edges
   initial begin
      #2;
      forever begin
         #15;
         if (run2) clk2 = ~clk2;
      end
   end

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (mux_rst_n !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mux_rst_n_in_reset: got %0b expected 0", mux_rst_n); end
      repeat (3) @(posedge clk0);
      #1 rst_n = 1'b1;
      tick();
      n_cmp++; if (alive !== 4'b0001) begin n_bad++; $display("[TB] FAIL rst_alive: got %b expected 0001", alive); end
      n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("[TB] FAIL rst_sel: got %0d expected 0", sel); end
      n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("[TB] FAIL rst_cur_sel: got %0d expected 0", cur_sel); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_req_ready: got %0b expected 1", req_ready); end
      n_cmp++; if (mux_rst_n !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mux_rst_n: got %0b expected 1", mux_rst_n); end
      n_cmp++; if ({done, err, err_code} !== 4'b0000) begin n_bad++; $display("[TB] FAIL rst_pulses: got done=%0b err=%0b code=%0d expected 0/0/0", done, err, err_code); end
   endtask

   task automatic test_switch();
      run2 = 1'b1;
      repeat (20) tick();
      n_cmp++; if (alive[2] !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_alive2: got %0b expected 1", alive[2]); end
      req_valid = 1'b1; req_sel = 2'd2;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("[TB] FAIL sw_sel: got %0d expected 2", sel); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_ready_in_settle: got %0b expected 0", req_ready); end
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k < 8) begin
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_early_done: cycle %0d got %0b expected 0", k, done); end
         end
      end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_done: got %0b expected 1", done); end
      n_cmp++; if (cur_sel !== 2'd2) begin n_bad++; $display("[TB] FAIL sw_cur_sel: got %0d expected 2", cur_sel); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_done_pulse: got %0b expected 0", done); end
   endtask

   task automatic test_not_alive();
      n_cmp++; if (alive[3] !== 1'b0) begin n_bad++; $display("[TB] FAIL na_alive3: got %0b expected 0", alive[3]); end
      req_valid = 1'b1; req_sel = 2'd3;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (err !== 1'b1 || err_code !== 2'd1) begin n_bad++; $display("[TB] FAIL na_err: got err=%0b code=%0d expected 1/1", err, err_code); end
      n_cmp++; if (sel !== 2'd2 || done !== 1'b0) begin n_bad++; $display("[TB] FAIL na_sel_done: got sel=%0d done=%0b expected 2/0", sel, done); end
      tick();
      n_cmp++; if (err !== 1'b0 || err_code !== 2'd1) begin n_bad++; $display("[TB] FAIL na_err_hold: got err=%0b code=%0d expected 0/1", err, err_code); end
   endtask

   task automatic test_same_sel();
      req_valid = 1'b1; req_sel = 2'd2;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("[TB] FAIL same_done: got done=%0b err=%0b expected 1/0", done, err); end
      n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("[TB] FAIL same_sel: got %0d expected 2", sel); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL same_ready: got %0b expected 1", req_ready); end
   endtask

   task automatic test_fallback_disabled();
      int  waited = 0;
      bit  pulsed = 1'b0;
      auto_fallback_en = 1'b0;
      run2 = 1'b0;
      while (alive[2] === 1'b1 && waited < 16 + 6) begin
         tick();
         waited++;
         if (done !== 1'b0 || err !== 1'b0) pulsed = 1'b1;
      end
      n_cmp++; if (alive[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL fbd_alive_drop: got %0b expected 0 within %0d cycles", alive[2], waited); end
      repeat (4) begin
         tick();
         if (done !== 1'b0 || err !== 1'b0) pulsed = 1'b1;
      end
      n_cmp++; if (pulsed !== 1'b0) begin n_bad++; $display("[TB] FAIL fbd_no_pulse: got pulse=%0b expected 0", pulsed); end
      n_cmp++; if (sel !== 2'd2 || cur_sel !== 2'd2 || mux_rst_n !== 1'b1) begin n_bad++; $display("[TB] FAIL fbd_hold: got sel=%0d cur=%0d mrn=%0b expected 2/2/1", sel, cur_sel, mux_rst_n); end
   endtask

   task automatic test_fallback();
      auto_fallback_en = 1'b1;
      req_valid = 1'b1; req_sel = 2'd2;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL fb_ready_drop: got %0b expected 0", req_ready); end
      tick();
      req_valid = 1'b0;
      n_cmp++; if (sel !== 2'd0 || mux_rst_n !== 1'b0 || done !== 1'b0) begin n_bad++; $display("[TB] FAIL fb_entry: got sel=%0d mrn=%0b done=%0b expected 0/0/0", sel, mux_rst_n, done); end
      tick();
      n_cmp++; if (mux_rst_n !== 1'b0) begin n_bad++; $display("[TB] FAIL fb_mrn_second: got %0b expected 0", mux_rst_n); end
      tick();
      n_cmp++; if (mux_rst_n !== 1'b1) begin n_bad++; $display("[TB] FAIL fb_mrn_release: got %0b expected 1", mux_rst_n); end
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k < 8) begin
            n_cmp++; if (err !== 1'b0 || done !== 1'b0) begin n_bad++; $display("[TB] FAIL fb_early_pulse: cycle %0d got err=%0b done=%0b expected 0/0", k, err, done); end
         end
      end
      n_cmp++; if (err !== 1'b1 || err_code !== 2'd3 || done !== 1'b0) begin n_bad++; $display("[TB] FAIL fb_err: got err=%0b code=%0d done=%0b expected 1/3/0", err, err_code, done); end
      n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("[TB] FAIL fb_cur_sel: got %0d expected 0", cur_sel); end
      auto_fallback_en = 1'b0;
   endtask

   task automatic test_abort();
      int  waited = 0;
      bit  saw_done = 1'b0;
      run1 = 1'b1;
      repeat (12) tick();
      n_cmp++; if (alive[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL ab_alive1: got %0b expected 1", alive[1]); end
      @(posedge clk1);
      run1 = 1'b0;
      repeat (13) tick();
      n_cmp++; if (alive[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL ab_alive1_before_req: got %0b expected 1", alive[1]); end
      req_valid = 1'b1; req_sel = 2'd1;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (sel !== 2'd1) begin n_bad++; $display("[TB] FAIL ab_sel: got %0d expected 1", sel); end
      while (mux_rst_n === 1'b1 && waited < 8 + 2) begin
         tick();
         waited++;
         if (done !== 1'b0) saw_done = 1'b1;
      end
      n_cmp++; if (mux_rst_n !== 1'b0 || saw_done !== 1'b0) begin n_bad++; $display("[TB] FAIL ab_abort: got mrn=%0b done_seen=%0b expected 0/0", mux_rst_n, saw_done); end
      n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("[TB] FAIL ab_sel_zero: got %0d expected 0", sel); end
      tick();
      n_cmp++; if (mux_rst_n !== 1'b0) begin n_bad++; $display("[TB] FAIL ab_mrn_second: got %0b expected 0", mux_rst_n); end
      tick();
      n_cmp++; if (mux_rst_n !== 1'b1) begin n_bad++; $display("[TB] FAIL ab_mrn_release: got %0b expected 1", mux_rst_n); end
      repeat (7) tick();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL ab_early_err: got %0b expected 0", err); end
      tick();
      n_cmp++; if (err !== 1'b1 || err_code !== 2'd2) begin n_bad++; $display("[TB] FAIL ab_err: got err=%0b code=%0d expected 1/2", err, err_code); end
      n_cmp++; if (cur_sel !== 2'd0) begin n_bad++; $display("[TB] FAIL ab_cur_sel: got %0d expected 0", cur_sel); end
   endtask

   task automatic test_reset_mid_settle();
      bit pulsed = 1'b0;
      run2 = 1'b1;
      repeat (20) tick();
      req_valid = 1'b1; req_sel = 2'd2;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("[TB] FAIL rms_sel: got %0d expected 2", sel); end
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (sel !== 2'd0 || cur_sel !== 2'd0 || mux_rst_n !== 1'b0) begin n_bad++; $display("[TB] FAIL rms_async: got sel=%0d cur=%0d mrn=%0b expected 0/0/0", sel, cur_sel, mux_rst_n); end
      n_cmp++; if (alive !== 4'b0001 || req_ready !== 1'b1 || err_code !== 2'd0) begin n_bad++; $display("[TB] FAIL rms_vals: got alive=%b ready=%0b code=%0d expected 0001/1/0", alive, req_ready, err_code); end
      repeat (3) begin
         tick();
         if (done !== 1'b0 || err !== 1'b0) pulsed = 1'b1;
      end
      rst_n = 1'b1;
      repeat (10) begin
         tick();
         if (done !== 1'b0 || err !== 1'b0) pulsed = 1'b1;
      end
      n_cmp++; if (pulsed !== 1'b0) begin n_bad++; $display("[TB] FAIL rms_no_pulse: got pulse=%0b expected 0", pulsed); end
      n_cmp++; if (sel !== 2'd0 || cur_sel !== 2'd0 || mux_rst_n !== 1'b1) begin n_bad++; $display("[TB] FAIL rms_after: got sel=%0d cur=%0d mrn=%0b expected 0/0/1", sel, cur_sel, mux_rst_n); end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_switch();
      test_not_alive();
      test_same_sel();
      test_fallback_disabled();
      test_fallback();
      test_abort();
      test_reset_mid_settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Control side of the glitch-free 4:1 clock mux. Owns the mux `sel` and `rst_n` inputs.
- Runs on the always-on reference clock clk0, which is also mux source 0.
- Monitors activity of all four candidate clocks and accepts switch requests over a valid/ready handshake.
- Applies a request only if the target clock is alive, waits a settle time, then reports done or error.
- Optionally falls back to source 0 when the active clock dies. Fallback reset-pulses the mux, because the mux cannot release a dead clock.

Parameters:
- SETTLE_CYC, 8: clk0 cycles from a sel change to done; must be ≥2.
- ALIVE_WIN, 16: clk0 cycles a source stays alive after its last detected toggle.
- MUXRST_CYC, 2: clk0 cycles mux_rst_n is held low on fallback or abort.

Ports:
- clk0  in  1  reference clock; also mux source 0.
- rst_n  in  1  reset.
- clk_in  in  4  monitored clocks; bit i feeds mux input i; bit 0 is ignored (source 0 is always alive).
- req_valid  in  1  switch request.
- req_sel  in  2  requested source.
- req_ready  out  1  high only in IDLE.
- auto_fallback_en  in  1  enables automatic fallback.
- sel  out  2  to mux sel.
- mux_rst_n  out  1  to mux rst_n.
- cur_sel  out  2  committed source.
- alive  out  4  per-source activity status.
- done  out  1  one-cycle pulse: request completed.
- err  out  1  one-cycle pulse.
- err_code  out  2  valid with err; held until the next err.

Behaviour:
- Reset (asynchronous, active-low): sel=0, cur_sel=0, done=0, err=0, err_code=0, alive=4'b0001, req_ready=1, FSM=IDLE.
- mux_rst_n = rst_n AND mux_rst_q, with mux_rst_q reset to 1.
- Activity monitor, per source 1..3:
  - Toggle flop in the clk_in[i] domain (async reset by rst_n), followed by a 2-flop synchronizer into clk0, followed by an edge detector.
  - Each detected edge reloads a down-counter to ALIVE_WIN; alive[i] = (counter != 0).
  - Counter resets to 0, so a source is not alive until it has toggled.
  - alive[0] is hard-wired to 1.
- FSM states: IDLE, SETTLE, MUXRST.
- IDLE, request accepted (req_valid && req_ready); target T = req_sel is latched:
  - T == cur_sel: done pulses on the next cycle; sel is unchanged.
  - !alive[T]: err pulses on the next cycle with err_code=1 (NOT_ALIVE); sel unchanged; stay in IDLE.
  - Otherwise: sel=T on the next cycle; load a counter with SETTLE_CYC; go to SETTLE.
- SETTLE:
  - Decrement each cycle.
  - At 0: cur_sel=T, done pulses, return to IDLE. Done follows the sel change by exactly SETTLE_CYC cycles.
  - If alive[T] drops before 0 (abort): sel=0, mux_rst_q=0, go to MUXRST. On exit, cur_sel=0 and err pulses with err_code=2 (LOST_IN_SETTLE).
  - Requests are not accepted (req_ready=0).
- Fallback (IDLE only): if auto_fallback_en && cur_sel != 0 && !alive[cur_sel], then sel=0, mux_rst_q=0, go to MUXRST. On exit, cur_sel=0 and err pulses with err_code=3 (FALLBACK).
- Fallback priority: a simultaneous req_valid is not accepted that cycle, because req_ready drops as the fallback is taken.
- MUXRST:
  - Hold mux_rst_q=0 for MUXRST_CYC cycles, then release and load SETTLE_CYC.
  - Then go to SETTLE, targeting 0, with the pending error flagged.
  - On completion, pulse err with the pending code instead of done.
- With auto_fallback_en=0, a dead cur_sel only shows as alive bit low; no action is taken.
- done and err never pulse in the same cycle.
- Reset mid-operation: everything returns to reset values immediately; no done or err is emitted.

Decomposition:
- Shared clk package holds:
  - err_code localparams: ERR_NONE=0, ERR_NOT_ALIVE=1, ERR_LOST=2, ERR_FALLBACK=3.
  - FSM state encodings.
  - Source-count constant (4).
- Sub-module clk_activity_mon, instantiated 3×. It contains the toggle flop, synchronizer, edge detect and window counter, and outputs alive.

Test Plan:
- Reset released; clk_in[3:1] idle → alive=0001, sel=0, cur_sel=0, req_ready=1, mux_rst_n=1 on the first clk0 edge after release.
- clk_in[2] runs at clk0/3; wait 20 cycles; request sel=2 → alive[2]=1; sel=2 on the next cycle; done exactly 8 cycles later; cur_sel=2.
- clk_in[3] stopped; request sel=3 → err with err_code=1 on the next cycle; sel stays 2; no done.
- Request sel=2 while cur_sel=2 → done on the next cycle; sel unchanged; req_ready back high.
- cur_sel=2, auto_fallback_en=1, clk_in[2] stops → alive[2] falls within ALIVE_WIN+4 cycles; sel=0; mux_rst_n low exactly 2 cycles; err code 3 after 8 settle cycles; cur_sel=0. Repeat with auto_fallback_en=0: no change.
- Switch to 1, then stop clk_in[1] mid-SETTLE → abort: sel=0, mux_rst_n low 2 cycles, err code 2, cur_sel=0. A separate run asserts rst_n mid-SETTLE → all reset values, no pulse.
